fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues word-aligned requests to instruction memory over a req/ack handshake, with one request outstanding at most.
- Presents each fetched instruction and its PC to the decoder through a one-entry valid/ready output buffer.
- Accepts PC redirects from branch/jump logic and discards wrong-path data, including responses still in flight.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decoder buffer and redirect.
// master = fetch stage, slave = memory/decoder/branch environment.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        redirect_misaligned;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, redirect_misaligned,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, redirect_misaligned,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// hands fetched words to the decoder through a one-entry valid/ready buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] pending_r;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;
    logic        instr_valid_r;
    logic        misaligned_r;

    logic        can_issue_s;
    logic        req_s;
    logic [31:0] target_s;
    logic [31:0] pc_next4_s;

    // Request decode: issue from IDLE only when the buffer can take the result.
    always_comb begin
        can_issue_s = !instr_valid_r || bus.instr_ready;
        target_s    = {bus.redirect_pc[31:2], 2'b00};
        pc_next4_s  = pc_r + 32'd4;
        req_s       = 1'b0;
        if (reset) begin
            req_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:       req_s = can_issue_s && !bus.redirect;
                WAIT, KILL: req_s = 1'b1;
                default:    req_s = 1'b0;
            endcase
        end
    end

    assign bus.imem_req            = req_s;
    assign bus.imem_addr           = pc_r;
    assign bus.instr_valid         = instr_valid_r;
    assign bus.instr               = instr_r;
    assign bus.instr_pc            = instr_pc_r;
    assign bus.redirect_misaligned = misaligned_r;

    // Fetch FSM, PC, redirect bookkeeping and decoder buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            pending_r     <= 32'h0000_0000;
            instr_r       <= NOP_INSTR;
            instr_pc_r    <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            misaligned_r  <= 1'b0;
        end else begin
            misaligned_r <= bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
            case (state_r)
                IDLE: begin
                    if (bus.redirect) begin
                        pc_r          <= target_s;
                        instr_valid_r <= 1'b0;
                        instr_r       <= NOP_INSTR;
                    end else if (can_issue_s && bus.imem_ack) begin
                        instr_r       <= bus.imem_rdata;
                        instr_pc_r    <= pc_r;
                        instr_valid_r <= 1'b1;
                        pc_r          <= pc_next4_s;
                    end else if (can_issue_s) begin
                        // Buffer is either empty or being consumed this cycle.
                        state_r       <= WAIT;
                        instr_valid_r <= 1'b0;
                        instr_r       <= NOP_INSTR;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus.redirect) begin
                        instr_valid_r <= 1'b0;
                        instr_r       <= NOP_INSTR;
                        if (bus.imem_ack) begin
                            pc_r    <= target_s;
                            state_r <= IDLE;
                        end else begin
                            pending_r <= target_s;
                            state_r   <= KILL;
                        end
                    end else if (bus.imem_ack) begin
                        instr_r       <= bus.imem_rdata;
                        instr_pc_r    <= pc_r;
                        instr_valid_r <= 1'b1;
                        pc_r          <= pc_next4_s;
                        state_r       <= IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                KILL: begin
                    if (bus.redirect) begin
                        pending_r     <= target_s;
                        instr_valid_r <= 1'b0;
                        instr_r       <= NOP_INSTR;
                    end
                    if (bus.imem_ack) begin
                        pc_r    <= bus.redirect ? target_s : pending_r;
                        state_r <= IDLE;
                    end else begin
                        state_r <= KILL;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    instr_valid_r <= 1'b0;
                    instr_r       <= NOP_INSTR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level model predicts the
// instruction stream, request handshake and buffer contents every cycle.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [31:0] exp_next;
    logic [31:0] issue_addr;
    bit          outstanding;
    bit          wanted;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    bit          m_mis;
    int          delivered;

    // memory / stimulus knobs
    int lat_cnt;
    int lat_tgt;
    int lat_max;
    int p_ready;
    int p_redir;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic step(input bit rst_in);
        bit          rdy;
        bit          red;
        bit          exp_req;
        bit          p_ack;
        bit          p_req;
        logic [31:0] rpc;

        @(negedge clk);
        reset = rst_in;
        rdy   = ($urandom_range(0, 99) < p_ready);
        red   = ($urandom_range(0, 99) < p_redir);
        if ($urandom_range(0, 3) == 0)
            rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else
            rpc = 32'($urandom_range(0, 4095));
        bus.instr_ready = rdy;
        bus.redirect    = red;
        bus.redirect_pc = rpc;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = $urandom;
        #1;
        exp_req = !rst_in && (outstanding || ((!m_valid || rdy) && !red));
        check_eq("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (exp_req && outstanding)
            check_eq("addr_stable", bus.imem_addr, issue_addr);
        else if (exp_req)
            check_eq("fetch_addr", bus.imem_addr, exp_next);

        // memory: per-request random latency, ack may coincide with req
        if (bus.imem_req) begin
            if (lat_cnt == 0)
                lat_tgt = $urandom_range(0, lat_max);
            if (lat_cnt >= lat_tgt) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
            end
        end
        #1;
        p_ack = bus.imem_ack;
        p_req = bus.imem_req;

        @(posedge clk);
        #1;
        if (rst_in) begin
            m_valid     = 1'b0;
            m_instr     = NOP;
            m_pc        = 32'h0;
            m_mis       = 1'b0;
            exp_next    = RESET_PC;
            outstanding = 1'b0;
            wanted      = 1'b0;
            lat_cnt     = 0;
        end else begin
            m_mis = red && (rpc[1:0] != 2'b00);
            if (exp_req && !outstanding) begin
                wanted     = 1'b1;
                issue_addr = exp_next;
            end
            if (red)
                wanted = 1'b0;
            if (red) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end else if (!m_valid || rdy) begin
                if (exp_req && p_ack && wanted) begin
                    m_valid  = 1'b1;
                    m_instr  = mem_word(exp_next);
                    m_pc     = exp_next;
                    exp_next = exp_next + 32'd4;
                    delivered++;
                end else begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                end
            end
            if (red)
                exp_next = {rpc[31:2], 2'b00};
            outstanding = exp_req && !p_ack;
            lat_cnt     = (p_req && !p_ack) ? lat_cnt + 1 : 0;
        end

        check_eq("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        check_eq("instr", bus.instr, m_instr);
        if (m_valid || rst_in)
            check_eq("instr_pc", bus.instr_pc, m_pc);
        check_eq("misaligned", 32'(bus.redirect_misaligned), 32'(m_mis));
    endtask

    initial begin
        reset           = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        lat_cnt   = 0;
        lat_tgt   = 0;
        lat_max   = 0;
        p_ready   = 100;
        p_redir   = 0;
        delivered = 0;
        exp_next  = RESET_PC;
        issue_addr = RESET_PC;
        outstanding = 1'b0;
        wanted    = 1'b0;
        m_valid   = 1'b0;
        m_instr   = NOP;
        m_pc      = 32'h0;
        m_mis     = 1'b0;

        repeat (2) step(1'b1);

        // zero-wait memory, decoder always ready: one instruction per cycle
        delivered = 0;
        repeat (20) step(1'b0);
        check_eq("throughput", 32'(delivered), 32'd20);

        // slow memory, stalls, redirects (some misaligned, some near wrap), rare resets
        lat_max = 3;
        p_ready = 60;
        p_redir = 10;
        delivered = 0;
        repeat (800) step($urandom_range(0, 199) == 0);

        // fast memory, heavy redirect traffic
        lat_max = 1;
        p_ready = 70;
        p_redir = 30;
        repeat (800) step($urandom_range(0, 199) == 0);

        // reset then long stall: buffer must hold
        step(1'b1);
        lat_max = 2;
        p_ready = 10;
        p_redir = 0;
        repeat (100) step(1'b0);

        check_eq("liveness", 32'(delivered > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
